// File: rtl/game_pkg.sv
// Shared types and constants for the sprite block controllers: sequencer states,
// fade level range, scan position widths and the 2x2 ordered-dither thresholds.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOLD_ON,
        FADE_OUT,
        HIDDEN,
        FADE_IN
    } state_t;

    localparam int ROW_W = 9;
    localparam int COL_W = 10;

    localparam logic [2:0] LEVEL_MAX = 3'd4;

    localparam logic [2:0] DITHER_T00 = 3'd0;
    localparam logic [2:0] DITHER_T01 = 3'd2;
    localparam logic [2:0] DITHER_T10 = 3'd3;
    localparam logic [2:0] DITHER_T11 = 3'd1;

    // A pixel is drawn when its threshold is below the fade level, so each level
    // step adds exactly one pixel of every 2x2 cell.
    function automatic logic [2:0] ditherThreshold(input logic rowLsb, input logic colLsb);
        logic [2:0] t;
        case ({rowLsb, colLsb})
            2'b00:   t = DITHER_T00;
            2'b01:   t = DITHER_T01;
            2'b10:   t = DITHER_T10;
            default: t = DITHER_T11;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Produces a single-cycle pulse on the first clock where the scan position is
// at the origin, even if the position is held there for several cycles.
module frame_tick_gen
    import game_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic [ROW_W-1:0] row,
    input  logic [COL_W-1:0] col,
    output logic             frame_tick
);

    logic w_atOrigin;
    logic r_atOriginPrev;

    assign w_atOrigin = (row == '0) && (col == '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_atOriginPrev <= 1'b0;
        end else begin
            r_atOriginPrev <= w_atOrigin;
        end
    end

    assign frame_tick = w_atOrigin && !r_atOriginPrev;

endmodule

// File: rtl/fade_sequencer.sv
// Frame-counted fade-out / hidden / fade-in sequencer for a fixed sprite block,
// gating the block's hit flag with a level-dependent 2x2 dither mask.
module fade_sequencer
    import game_pkg::*;
#(
    parameter int ON_FRAMES   = 30,
    parameter int STEP_FRAMES = 4,
    parameter int OFF_FRAMES  = 60
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [ROW_W-1:0] row,
    input  logic [COL_W-1:0] col,
    input  logic             start,
    input  logic             abort,
    input  logic             repeat_en,
    input  logic             block_here,
    input  logic [7:0]       block_color,
    output logic             here,
    output logic [7:0]       color,
    output logic [2:0]       level,
    output logic             busy,
    output logic             done
);

    localparam logic [7:0] ON_LAST   = 8'(ON_FRAMES - 1);
    localparam logic [7:0] STEP_LAST = 8'(STEP_FRAMES - 1);
    localparam logic [7:0] OFF_LAST  = 8'(OFF_FRAMES - 1);

    state_t     r_state;
    logic [2:0] r_level;
    logic [7:0] r_frameCnt;
    logic       r_busy;
    logic       r_done;
    logic       r_here;
    logic [7:0] r_color;

    logic       w_frameTick;
    logic [2:0] w_threshold;
    logic       w_shown;

    frame_tick_gen u_frameTickGen (
        .clk        (clk),
        .resetn     (resetn),
        .row        (row),
        .col        (col),
        .frame_tick (w_frameTick)
    );

    // Abort overrides everything, including a simultaneous start. A tick that
    // arrives with start is not counted because IDLE never looks at the tick.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_level    <= LEVEL_MAX;
            r_frameCnt <= 8'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                r_state    <= IDLE;
                r_level    <= LEVEL_MAX;
                r_frameCnt <= 8'd0;
                r_busy     <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start) begin
                            r_state    <= HOLD_ON;
                            r_frameCnt <= 8'd0;
                            r_busy     <= 1'b1;
                        end
                    end
                    HOLD_ON: begin
                        if (w_frameTick) begin
                            if (r_frameCnt == ON_LAST) begin
                                r_state    <= FADE_OUT;
                                r_frameCnt <= 8'd0;
                            end else begin
                                r_frameCnt <= r_frameCnt + 8'd1;
                            end
                        end
                    end
                    FADE_OUT: begin
                        if (w_frameTick) begin
                            if (r_frameCnt == STEP_LAST) begin
                                r_frameCnt <= 8'd0;
                                r_level    <= r_level - 3'd1;
                                if (r_level == 3'd1) begin
                                    r_state <= HIDDEN;
                                end
                            end else begin
                                r_frameCnt <= r_frameCnt + 8'd1;
                            end
                        end
                    end
                    HIDDEN: begin
                        if (w_frameTick) begin
                            if (r_frameCnt == OFF_LAST) begin
                                r_state    <= FADE_IN;
                                r_frameCnt <= 8'd0;
                            end else begin
                                r_frameCnt <= r_frameCnt + 8'd1;
                            end
                        end
                    end
                    FADE_IN: begin
                        if (w_frameTick) begin
                            if (r_frameCnt == STEP_LAST) begin
                                r_frameCnt <= 8'd0;
                                r_level    <= r_level + 3'd1;
                                if (r_level == LEVEL_MAX - 3'd1) begin
                                    if (repeat_en) begin
                                        r_state <= HOLD_ON;
                                    end else begin
                                        r_state <= IDLE;
                                        r_busy  <= 1'b0;
                                        r_done  <= 1'b1;
                                    end
                                end
                            end else begin
                                r_frameCnt <= r_frameCnt + 8'd1;
                            end
                        end
                    end
                    default: begin
                        r_state    <= IDLE;
                        r_level    <= LEVEL_MAX;
                        r_frameCnt <= 8'd0;
                        r_busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign w_threshold = ditherThreshold(row[0], col[0]);
    assign w_shown     = block_here && (w_threshold < r_level);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_here  <= 1'b0;
            r_color <= 8'd0;
        end else begin
            r_here  <= w_shown;
            r_color <= w_shown ? block_color : 8'd0;
        end
    end

    assign here  = r_here;
    assign color = r_color;
    assign level = r_level;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_fade_sequencer.sv
// Randomized self-checking bench for fade_sequencer; expected levels come from a
// closed-form schedule of the fade cycle rather than a state machine.
module tb_fade_sequencer;

    localparam int ON    = 2;
    localparam int STEP  = 1;
    localparam int OFF   = 3;
    localparam int TOTAL = ON + 4 * STEP + OFF + 4 * STEP;
    localparam int THR[4] = '{0, 2, 3, 1};

    logic       clk;
    logic       resetn;
    logic [8:0] row;
    logic [9:0] col;
    logic       start;
    logic       abort;
    logic       repeat_en;
    logic       block_here;
    logic [7:0] block_color;
    logic       here;
    logic [7:0] color;
    logic [2:0] level;
    logic       busy;
    logic       done;

    int total;
    int bad;

    fade_sequencer #(
        .ON_FRAMES   (ON),
        .STEP_FRAMES (STEP),
        .OFF_FRAMES  (OFF)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .row         (row),
        .col         (col),
        .start       (start),
        .abort       (abort),
        .repeat_en   (repeat_en),
        .block_here  (block_here),
        .block_color (block_color),
        .here        (here),
        .color       (color),
        .level       (level),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Level expected after k counted frame ticks since the sequence began.
    function automatic int refLevel(input int k);
        int lv;
        if (k < ON)                       lv = 4;
        else if (k < ON + 4 * STEP)       lv = 4 - (k - ON) / STEP;
        else if (k < ON + 4 * STEP + OFF) lv = 0;
        else                              lv = (k - ON - 4 * STEP - OFF) / STEP;
        if (lv > 4) lv = 4;
        return lv;
    endfunction

    function automatic logic expShown(input int lv);
        int idx;
        idx = {row[0], col[0]};
        return block_here && (THR[idx] < lv);
    endfunction

    function automatic logic [8:0] randRow();
        return 9'($urandom_range(1, 479));
    endfunction

    function automatic logic [9:0] randCol();
        return 10'($urandom_range(1, 639));
    endfunction

    task automatic cyc(input logic [8:0] r, input logic [9:0] c, input logic bh,
                       input logic [7:0] bc, input logic st, input logic ab);
        @(negedge clk);
        row         = r;
        col         = c;
        block_here  = bh;
        block_color = bc;
        start       = st;
        abort       = ab;
        @(posedge clk);
        #1;
    endtask

    task automatic randCyc();
        cyc(randRow(), randCol(), 1'($urandom_range(0, 1)), 8'($urandom), 1'b0, 1'b0);
    endtask

    task automatic tickCyc();
        cyc(9'd0, 10'd0, 1'($urandom_range(0, 1)), 8'($urandom), 1'b0, 1'b0);
    endtask

    task automatic runTicks(input string tag, input logic expectLoop);
        int lvl;
        logic exp;
        for (int k = 1; k <= TOTAL; k++) begin
            lvl = refLevel(k - 1);
            for (int f = 0; f < int'($urandom_range(1, 3)); f++) begin
                randCyc();
                exp = expShown(lvl);
                total++;
                if ({here, color} !== {exp, exp ? block_color : 8'd0}) begin
                    bad++;
                    $display("[TB] FAIL %s pixel k=%0d: got here=%0b color=%0d, want here=%0b color=%0d",
                             tag, k, here, color, exp, exp ? block_color : 8'd0);
                end
                total++;
                if (done !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL %s idle_done k=%0d: got %0b, want 0", tag, k, done);
                end
            end
            tickCyc();
            total++;
            if (level !== 3'(refLevel(k))) begin
                bad++;
                $display("[TB] FAIL %s level tick=%0d: got %0d, want %0d", tag, k, level, refLevel(k));
            end
            total++;
            if ({done, busy} !== {(k == TOTAL) && !expectLoop, (k < TOTAL) || expectLoop}) begin
                bad++;
                $display("[TB] FAIL %s done/busy tick=%0d: got %0b/%0b, want %0b/%0b", tag, k, done, busy,
                         (k == TOTAL) && !expectLoop, (k < TOTAL) || expectLoop);
            end
        end
        randCyc();
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s done_width: got %0b, want 0", tag, done);
        end
    endtask

    task automatic test_full_sequence(input string tag);
        randCyc();
        cyc(randRow(), randCol(), 1'b0, 8'd0, 1'b1, 1'b0);
        total++;
        if ({busy, level} !== {1'b1, 3'd4}) begin
            bad++;
            $display("[TB] FAIL %s start: got busy=%0b level=%0d, want 1/4", tag, busy, level);
        end
        runTicks(tag, 1'b0);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({here, color, level, busy, done} !== {1'b0, 8'd0, 3'd4, 1'b0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL reset_values: got here=%0b color=%0d level=%0d busy=%0b done=%0b, want 0/0/4/0/0",
                     here, color, level, busy, done);
        end
        cyc(9'd3, 10'd3, 1'b1, 8'd5, 1'b0, 1'b0);
        total++;
        if ({here, color} !== {1'b1, 8'd5}) begin
            bad++;
            $display("[TB] FAIL reset_color: got here=%0b color=%0d, want 1/5", here, color);
        end
    endtask

    task automatic test_frame_tick();
        cyc(randRow(), randCol(), 1'b0, 8'd0, 1'b1, 1'b1);
        total++;
        if ({busy, level} !== {1'b0, 3'd4}) begin
            bad++;
            $display("[TB] FAIL start_abort: got busy=%0b level=%0d, want 0/4", busy, level);
        end
        tickCyc();
        randCyc();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL start_abort_idle: got busy=%0b, want 0", busy);
        end
        cyc(randRow(), randCol(), 1'b0, 8'd0, 1'b1, 1'b0);
        repeat (5) tickCyc();
        total++;
        if ({busy, level} !== {1'b1, 3'd4}) begin
            bad++;
            $display("[TB] FAIL held_origin: got busy=%0b level=%0d, want 1/4", busy, level);
        end
        randCyc();
        tickCyc();
        total++;
        if (level !== 3'd4) begin
            bad++;
            $display("[TB] FAIL second_tick: got level=%0d, want 4", level);
        end
        randCyc();
        tickCyc();
        total++;
        if (level !== 3'd3) begin
            bad++;
            $display("[TB] FAIL third_tick: got level=%0d, want 3", level);
        end
        cyc(randRow(), randCol(), 1'b0, 8'd0, 1'b0, 1'b1);
    endtask

    task automatic test_dither();
        logic exp;
        randCyc();
        cyc(randRow(), randCol(), 1'b0, 8'd0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            randCyc();
            tickCyc();
        end
        total++;
        if (level !== 3'd2) begin
            bad++;
            $display("[TB] FAIL dither_level: got %0d, want 2", level);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(9'(2 * $urandom_range(1, 200) + (i >> 1)), 10'(2 * $urandom_range(1, 300) + (i & 1)),
                1'b1, 8'($urandom_range(1, 255)), 1'b0, 1'b0);
            exp = (i == 0) || (i == 3);
            total++;
            if ({here, color} !== {exp, exp ? block_color : 8'd0}) begin
                bad++;
                $display("[TB] FAIL dither_%0d: got here=%0b color=%0d, want here=%0b color=%0d",
                         i, here, color, exp, exp ? block_color : 8'd0);
            end
        end
        cyc(randRow(), randCol(), 1'b0, 8'd0, 1'b0, 1'b1);
    endtask

    task automatic test_abort();
        randCyc();
        cyc(randRow(), randCol(), 1'b0, 8'd0, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            randCyc();
            tickCyc();
        end
        total++;
        if ({busy, level} !== {1'b1, 3'd0}) begin
            bad++;
            $display("[TB] FAIL hidden: got busy=%0b level=%0d, want 1/0", busy, level);
        end
        cyc(randRow(), randCol(), 1'b0, 8'd0, 1'b0, 1'b1);
        total++;
        if ({busy, level, done} !== {1'b0, 3'd4, 1'b0}) begin
            bad++;
            $display("[TB] FAIL abort: got busy=%0b level=%0d done=%0b, want 0/4/0", busy, level, done);
        end
        for (int k = 0; k < 2; k++) begin
            randCyc();
            tickCyc();
        end
        total++;
        if ({busy, done} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL abort_stays_idle: got busy=%0b done=%0b, want 0/0", busy, done);
        end
        test_full_sequence("restart");
    endtask

    task automatic test_repeat();
        repeat_en = 1'b1;
        randCyc();
        cyc(randRow(), randCol(), 1'b0, 8'd0, 1'b1, 1'b0);
        runTicks("loop", 1'b1);
        repeat_en = 1'b0;
        runTicks("loop_end", 1'b0);
    endtask

    task automatic test_back_to_back();
        test_full_sequence("b2b_a");
        test_full_sequence("b2b_b");
        randCyc();
        cyc(9'd0, 10'd0, 1'b0, 8'd0, 1'b1, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            randCyc();
            tickCyc();
            total++;
            if (level !== 3'(refLevel(k))) begin
                bad++;
                $display("[TB] FAIL start_with_tick %0d: got level=%0d, want %0d", k, level, refLevel(k));
            end
        end
        cyc(randRow(), randCol(), 1'b0, 8'd0, 1'b0, 1'b1);
    endtask

    task automatic test_async_reset();
        randCyc();
        cyc(randRow(), randCol(), 1'b1, 8'd9, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            randCyc();
            tickCyc();
        end
        cyc(9'd1, 10'd1, 1'b1, 8'd7, 1'b0, 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        total++;
        if ({here, color, level, busy, done} !== {1'b0, 8'd0, 3'd4, 1'b0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL async_reset: got here=%0b color=%0d level=%0d busy=%0b done=%0b, want 0/0/4/0/0",
                     here, color, level, busy, done);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            randCyc();
            tickCyc();
        end
        total++;
        if ({busy, level} !== {1'b0, 3'd4}) begin
            bad++;
            $display("[TB] FAIL reset_wait_idle: got busy=%0b level=%0d, want 0/4", busy, level);
        end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        resetn      = 1'b0;
        row         = 9'd5;
        col         = 10'd5;
        start       = 1'b0;
        abort       = 1'b0;
        repeat_en   = 1'b0;
        block_here  = 1'b0;
        block_color = 8'd0;
        test_reset();
        test_frame_tick();
        test_full_sequence("full");
        test_dither();
        test_abort();
        test_repeat();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
